line_frame_padder: RTL and testbench

- Streaming video conformer in the VP chain. Forces every line to exactly H_DISP active pixels and every frame to exactly V_DISP active lines.
- Short lines are padded with a fill colour. Long lines are cropped.
- Missing lines at frame end are synthesised as fill lines before the next frame's sync is forwarded.
- Sits between a source with irregular geometry (scaler/decoder) and a fixed-timing consumer (framebuffer writer, HDMI encoder).

---
 rtl/line_frame_padder.sv | 233 +++++++++++++++++++++++
 tb/tb_line_frame_padder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_frame_padder.sv
// Conforms a pixel stream to H_DISP x V_DISP: pads short lines, crops long ones, synthesises missing lines.
// All outputs registered with 1-cycle latency; no backpressure, one input pixel is consumed every cycle.
module line_frame_padder #(
  parameter int DW     = 24,
  parameter int H_DISP = 1280,
  parameter int V_DISP = 720,
  parameter int H_GAP  = 16
) (
  input  logic                      pre_clk,
  input  logic                      rst,
  input  logic                      EN,
  input  logic                      vpad_en,
  input  logic [1:0]                mode,
  input  logic [DW-1:0]             color,
  input  logic                      err_clr,
  input  logic                      pre_vs,
  input  logic                      pre_de,
  input  logic [DW-1:0]             pre_data,
  output logic                      post_clk,
  output logic                      post_vs,
  output logic                      post_de,
  output logic [DW-1:0]             post_data,
  output logic [$clog2(V_DISP+1):0] lines_in,
  output logic                      err_long,
  output logic                      err_overlap,
  output logic                      err_vdrop
);

  localparam int XW = $clog2(H_DISP + 1);
  localparam int YW = $clog2(V_DISP + 1);
  localparam int LW = YW + 1;
  localparam int GW = $clog2(H_GAP + 1);
  localparam logic [XW-1:0] X_MAX  = XW'(H_DISP);
  localparam logic [XW-1:0] X_LAST = XW'(H_DISP - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(V_DISP);
  localparam logic [GW-1:0] G_LAST = GW'(H_GAP - 1);
  localparam logic [LW-1:0] L_SAT  = '1;

  typedef enum logic [2:0] {IDLE, RECV, HFILL, VFILL_LINE, VFILL_GAP} state_t;

  state_t        state;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [YW-1:0] remaining;
  logic [GW-1:0] gap_cnt;
  logic [LW-1:0] in_cnt;
  logic          pre_vs_d;

  logic [DW-1:0] fill;
  logic          vs_rise;
  logic          in_line;
  logic [YW-1:0] y_inc;
  logic [YW-1:0] y_end;
  logic [LW-1:0] in_inc;
  logic [LW-1:0] in_end;
  logic          vfill_go;

  assign post_clk = pre_clk;

  always_comb begin
    case (mode)
      2'b10:   fill = '1;
      2'b11:   fill = color;
      default: fill = '0;
    endcase
  end

  // A vsync edge inside a line closes that line, so it is counted before the frame decision.
  assign vs_rise  = pre_vs & ~pre_vs_d;
  assign in_line  = (state == RECV) || (state == HFILL);
  assign y_inc    = (y_cnt == Y_MAX) ? y_cnt : y_cnt + 1'b1;
  assign in_inc   = (in_cnt == L_SAT) ? in_cnt : in_cnt + 1'b1;
  assign y_end    = in_line ? y_inc : y_cnt;
  assign in_end   = in_line ? in_inc : in_cnt;
  assign vfill_go = vpad_en && (y_end != '0) && (y_end < Y_MAX);

  always_ff @(posedge pre_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      x_cnt       <= '0;
      y_cnt       <= '0;
      remaining   <= '0;
      gap_cnt     <= '0;
      in_cnt      <= '0;
      pre_vs_d    <= 1'b0;
      post_vs     <= 1'b0;
      post_de     <= 1'b0;
      post_data   <= '0;
      lines_in    <= '0;
      err_long    <= 1'b0;
      err_overlap <= 1'b0;
      err_vdrop   <= 1'b0;
    end else begin
      pre_vs_d <= pre_vs;
      if (err_clr) begin
        err_long    <= 1'b0;
        err_overlap <= 1'b0;
        err_vdrop   <= 1'b0;
      end
      if (!EN) begin
        state     <= IDLE;
        x_cnt     <= '0;
        y_cnt     <= '0;
        remaining <= '0;
        gap_cnt   <= '0;
        in_cnt    <= '0;
        post_vs   <= pre_vs;
        post_de   <= pre_de;
        post_data <= pre_data;
      end else if (vs_rise && (state == IDLE || in_line)) begin
        lines_in  <= in_end;
        in_cnt    <= '0;
        x_cnt     <= '0;
        gap_cnt   <= '0;
        post_de   <= 1'b0;
        post_data <= '0;
        if (vfill_go) begin
          state     <= VFILL_LINE;
          remaining <= Y_MAX - y_end;
          y_cnt     <= y_end;
          post_vs   <= 1'b0;
        end else begin
          state   <= IDLE;
          y_cnt   <= '0;
          post_vs <= pre_vs;
        end
      end else begin
        case (state)
          IDLE: begin
            post_vs <= pre_vs;
            if (pre_de) begin
              post_de   <= 1'b1;
              post_data <= pre_data;
              x_cnt     <= XW'(1);
              state     <= RECV;
            end else begin
              post_de   <= 1'b0;
              post_data <= '0;
            end
          end
          RECV: begin
            post_vs <= pre_vs;
            if (pre_de) begin
              if (x_cnt < X_MAX) begin
                post_de   <= 1'b1;
                post_data <= pre_data;
                x_cnt     <= x_cnt + 1'b1;
              end else begin
                post_de   <= 1'b0;
                post_data <= '0;
                err_long  <= 1'b1;
              end
            end else if (x_cnt < X_MAX) begin
              post_de   <= 1'b1;
              post_data <= fill;
              if (x_cnt == X_LAST) begin
                state  <= IDLE;
                x_cnt  <= '0;
                y_cnt  <= y_inc;
                in_cnt <= in_inc;
              end else begin
                state <= HFILL;
                x_cnt <= x_cnt + 1'b1;
              end
            end else begin
              post_de   <= 1'b0;
              post_data <= '0;
              state     <= IDLE;
              x_cnt     <= '0;
              y_cnt     <= y_inc;
              in_cnt    <= in_inc;
            end
          end
          HFILL: begin
            post_vs <= pre_vs;
            post_de <= 1'b1;
            if (pre_de) begin
              post_data   <= pre_data;
              x_cnt       <= XW'(1);
              y_cnt       <= y_inc;
              in_cnt      <= in_inc;
              err_overlap <= 1'b1;
              state       <= RECV;
            end else begin
              post_data <= fill;
              if (x_cnt == X_LAST) begin
                state  <= IDLE;
                x_cnt  <= '0;
                y_cnt  <= y_inc;
                in_cnt <= in_inc;
              end else begin
                x_cnt <= x_cnt + 1'b1;
              end
            end
          end
          VFILL_LINE: begin
            post_vs   <= 1'b0;
            post_de   <= 1'b1;
            post_data <= fill;
            if (pre_de) err_vdrop <= 1'b1;
            if (x_cnt == X_LAST) begin
              state   <= VFILL_GAP;
              x_cnt   <= '0;
              gap_cnt <= '0;
            end else begin
              x_cnt <= x_cnt + 1'b1;
            end
          end
          VFILL_GAP: begin
            post_vs   <= 1'b0;
            post_de   <= 1'b0;
            post_data <= '0;
            if (pre_de) err_vdrop <= 1'b1;
            if (gap_cnt == G_LAST) begin
              gap_cnt   <= '0;
              remaining <= remaining - 1'b1;
              if (remaining == YW'(1)) begin
                state <= IDLE;
                y_cnt <= '0;
              end else begin
                state <= VFILL_LINE;
              end
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_frame_padder.sv
// Directed bench for line_frame_padder at H_DISP=8, V_DISP=4, H_GAP=2.
module tb_line_frame_padder;
  localparam int DW = 24;

  logic          pre_clk;
  logic          rst;
  logic          EN;
  logic          vpad_en;
  logic [1:0]    mode;
  logic [DW-1:0] color;
  logic          err_clr;
  logic          pre_vs;
  logic          pre_de;
  logic [DW-1:0] pre_data;
  logic          post_clk;
  logic          post_vs;
  logic          post_de;
  logic [DW-1:0] post_data;
  logic [3:0]    lines_in;
  logic          err_long;
  logic          err_overlap;
  logic          err_vdrop;

  int tests = 0;
  int fails = 0;

  line_frame_padder #(.DW(DW), .H_DISP(8), .V_DISP(4), .H_GAP(2)) dut (
    .pre_clk(pre_clk), .rst(rst), .EN(EN), .vpad_en(vpad_en), .mode(mode),
    .color(color), .err_clr(err_clr), .pre_vs(pre_vs), .pre_de(pre_de),
    .pre_data(pre_data), .post_clk(post_clk), .post_vs(post_vs), .post_de(post_de),
    .post_data(post_data), .lines_in(lines_in), .err_long(err_long),
    .err_overlap(err_overlap), .err_vdrop(err_vdrop)
  );

  initial begin
    pre_clk = 1'b0;
    forever #5 pre_clk = ~pre_clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench still running at %0t, expected to finish earlier", $time);
    $fatal(1, "timeout");
  end

  // Drive one input cycle, then sample 1 time unit after the capturing edge.
  task automatic cyc(input logic vs, input logic de, input logic [DW-1:0] d);
    pre_vs = vs; pre_de = de; pre_data = d;
    @(posedge pre_clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; EN = 1'b0; vpad_en = 1'b0; mode = 2'b00; color = '0; err_clr = 1'b0;
    pre_vs = 1'b0; pre_de = 1'b0; pre_data = '0;
    repeat (2) @(posedge pre_clk);
    #1;
    tests++;
    if (post_vs !== 1'b0 || post_de !== 1'b0 || post_data !== '0 || lines_in !== 4'd0 ||
        err_long !== 1'b0 || err_overlap !== 1'b0 || err_vdrop !== 1'b0) begin
      fails++;
      $display("FAIL reset: vs=%b de=%b data=%h lines=%0d flags=%b%b%b, expected all zero",
               post_vs, post_de, post_data, lines_in, err_long, err_overlap, err_vdrop);
    end
    tests++;
    if (post_clk !== pre_clk) begin
      fails++;
      $display("FAIL post_clk: got %b, expected %b", post_clk, pre_clk);
    end
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    logic          sv, sd;
    logic [DW-1:0] dd;
    EN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sv = (i == 0);
      sd = (i >= 1 && i <= 5);
      dd = sd ? DW'(i) : '0;
      cyc(sv, sd, dd);
      tests++;
      if (post_vs !== sv || post_de !== sd || post_data !== dd) begin
        fails++;
        $display("FAIL passthrough cyc%0d: vs=%b de=%b data=%h, expected vs=%b de=%b data=%h",
                 i, post_vs, post_de, post_data, sv, sd, dd);
      end
    end
    tests++;
    if ({err_long, err_overlap, err_vdrop} !== 3'b000) begin
      fails++;
      $display("FAIL passthrough flags: got %b%b%b, expected 000", err_long, err_overlap, err_vdrop);
    end
  endtask

  task automatic test_hpad();
    logic          sd, ee;
    logic [DW-1:0] dd, ed;
    EN = 1'b1; vpad_en = 1'b0; mode = 2'b11; color = 24'hABCDEF;
    for (int i = 0; i < 10; i++) begin
      sd = (i >= 1 && i <= 5);
      dd = sd ? DW'(i) : '0;
      ee = (i >= 1 && i <= 8);
      ed = sd ? dd : 24'hABCDEF;
      cyc(1'b0, sd, dd);
      tests++;
      if (post_de !== ee || (ee && post_data !== ed)) begin
        fails++;
        $display("FAIL hpad cyc%0d: de=%b data=%h, expected de=%b data=%h", i, post_de, post_data, ee, ed);
      end
    end
    tests++;
    if (dut.y_cnt !== 1) begin
      fails++;
      $display("FAIL hpad y_cnt: got %0d, expected 1", dut.y_cnt);
    end
  endtask

  task automatic test_crop();
    for (int i = 0; i < 11; i++) begin
      cyc(1'b0, 1'b1, DW'(8'h10 + i));
      tests++;
      if (post_de !== (i < 8) || (i < 8 && post_data !== DW'(8'h10 + i))) begin
        fails++;
        $display("FAIL crop cyc%0d: de=%b data=%h, expected de=%b data=%h",
                 i, post_de, post_data, (i < 8), DW'(8'h10 + i));
      end
      if (i == 7) begin
        tests++;
        if (err_long !== 1'b0) begin
          fails++;
          $display("FAIL crop early err_long: got %b, expected 0", err_long);
        end
      end
    end
    cyc(1'b0, 1'b0, '0);
    tests++;
    if (err_long !== 1'b1 || post_de !== 1'b0 || dut.y_cnt !== 2) begin
      fails++;
      $display("FAIL crop end: err_long=%b de=%b y=%0d, expected 1 0 2", err_long, post_de, dut.y_cnt);
    end
    err_clr = 1'b1;
    cyc(1'b0, 1'b0, '0);
    err_clr = 1'b0;
    tests++;
    if (err_long !== 1'b0) begin
      fails++;
      $display("FAIL err_clr: err_long=%b, expected 0", err_long);
    end
  endtask

  task automatic test_overlap();
    logic          sd, ee;
    logic [DW-1:0] dd, ed;
    for (int i = 0; i < 14; i++) begin
      sd = (i <= 2) || (i >= 5 && i <= 12);
      dd = (i <= 2) ? DW'(8'h21 + i) : (sd ? DW'(8'h31 + i - 5) : '0);
      ee = (i <= 12);
      ed = sd ? dd : 24'hABCDEF;
      cyc(1'b0, sd, dd);
      tests++;
      if (post_de !== ee || (ee && post_data !== ed)) begin
        fails++;
        $display("FAIL overlap cyc%0d: de=%b data=%h, expected de=%b data=%h", i, post_de, post_data, ee, ed);
      end
      if (i == 4) begin
        tests++;
        if (err_overlap !== 1'b0) begin
          fails++;
          $display("FAIL overlap early flag: got %b, expected 0", err_overlap);
        end
      end
    end
    tests++;
    if (err_overlap !== 1'b1 || dut.y_cnt !== 4) begin
      fails++;
      $display("FAIL overlap end: err_overlap=%b y=%0d, expected 1 4", err_overlap, dut.y_cnt);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, (i < 8), (i < 8) ? DW'(8'h41 + i) : '0);
      tests++;
      if (post_de !== (i < 8) || (i < 8 && post_data !== DW'(8'h41 + i))) begin
        fails++;
        $display("FAIL saturate cyc%0d: de=%b data=%h, expected de=%b data=%h",
                 i, post_de, post_data, (i < 8), DW'(8'h41 + i));
      end
    end
    tests++;
    if (dut.y_cnt !== 4) begin
      fails++;
      $display("FAIL saturate y_cnt: got %0d, expected 4", dut.y_cnt);
    end
  endtask

  task automatic test_vpad();
    logic ee;
    // y_cnt is already at V_DISP: the frame closes with no synthesis even with vpad_en set.
    vpad_en = 1'b1;
    cyc(1'b1, 1'b0, '0);
    tests++;
    if (post_vs !== 1'b1 || lines_in !== 4'd5 || dut.y_cnt !== 0) begin
      fails++;
      $display("FAIL vpad full frame: vs=%b lines=%0d y=%0d, expected 1 5 0", post_vs, lines_in, dut.y_cnt);
    end
    cyc(1'b0, 1'b0, '0);
    mode = 2'b10;
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < 9; i++) cyc(1'b0, (i < 8), DW'(8'h50 + i));
    cyc(1'b1, 1'b0, '0);
    tests++;
    if (post_vs !== 1'b0 || post_de !== 1'b0 || lines_in !== 4'd2) begin
      fails++;
      $display("FAIL vpad rise: vs=%b de=%b lines=%0d, expected 0 0 2", post_vs, post_de, lines_in);
    end
    for (int k = 0; k < 20; k++) begin
      ee = (k < 8) || (k >= 10 && k < 18);
      cyc(1'b1, (k == 8), 24'h000055);
      tests++;
      if (post_vs !== 1'b0 || post_de !== ee || (ee && post_data !== 24'hFFFFFF)) begin
        fails++;
        $display("FAIL vfill cyc%0d: vs=%b de=%b data=%h, expected vs=0 de=%b data=ffffff",
                 k, post_vs, post_de, post_data, ee);
      end
    end
    cyc(1'b1, 1'b0, '0);
    tests++;
    if (post_vs !== 1'b1 || post_de !== 1'b0 || err_vdrop !== 1'b1) begin
      fails++;
      $display("FAIL vfill end: vs=%b de=%b err_vdrop=%b, expected 1 0 1", post_vs, post_de, err_vdrop);
    end
    // Same shape with vpad_en low: the vsync goes straight through.
    vpad_en = 1'b0;
    cyc(1'b0, 1'b0, '0);
    for (int l = 0; l < 3; l++)
      for (int i = 0; i < 9; i++) cyc(1'b0, (i < 8), DW'(8'h60 + i));
    cyc(1'b1, 1'b0, '0);
    tests++;
    if (post_vs !== 1'b1 || lines_in !== 4'd3) begin
      fails++;
      $display("FAIL nopad rise: vs=%b lines=%0d, expected 1 3", post_vs, lines_in);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, '0);
      tests++;
      if (post_vs !== 1'b1 || post_de !== 1'b0) begin
        fails++;
        $display("FAIL nopad cyc%0d: vs=%b de=%b, expected 1 0", k, post_vs, post_de);
      end
    end
    cyc(1'b0, 1'b0, '0);
  endtask

  task automatic test_reset_mid();
    logic          sd, ee;
    logic [DW-1:0] dd, ed;
    vpad_en = 1'b1;
    for (int i = 0; i < 9; i++) cyc(1'b0, (i < 8), DW'(8'h70 + i));
    cyc(1'b1, 1'b0, '0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, '0);
    tests++;
    if (post_de !== 1'b1 || post_data !== 24'hFFFFFF || lines_in !== 4'd1) begin
      fails++;
      $display("FAIL pre-reset vfill: de=%b data=%h lines=%0d, expected 1 ffffff 1", post_de, post_data, lines_in);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (post_vs !== 1'b0 || post_de !== 1'b0 || post_data !== '0 || lines_in !== 4'd0 ||
        {err_long, err_overlap, err_vdrop} !== 3'b000) begin
      fails++;
      $display("FAIL async reset: vs=%b de=%b data=%h lines=%0d flags=%b%b%b, expected all zero",
               post_vs, post_de, post_data, lines_in, err_long, err_overlap, err_vdrop);
    end
    pre_vs = 1'b0;
    @(posedge pre_clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      sd = (i < 5);
      dd = sd ? DW'(8'h61 + i) : '0;
      ee = (i < 8);
      ed = sd ? dd : 24'hFFFFFF;
      cyc(1'b0, sd, dd);
      tests++;
      if (post_de !== ee || (ee && post_data !== ed)) begin
        fails++;
        $display("FAIL post-reset cyc%0d: de=%b data=%h, expected de=%b data=%h", i, post_de, post_data, ee, ed);
      end
    end
    tests++;
    if (dut.y_cnt !== 1) begin
      fails++;
      $display("FAIL post-reset y_cnt: got %0d, expected 1", dut.y_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_hpad();
    test_crop();
    test_overlap();
    test_saturate();
    test_vpad();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
